// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver_if
//  Description : Bundle of load/data inputs and scanned display outputs for
//                the four-digit seven-segment scan driver.
//                  load       - capture strobe for value/dp_in
//                  value      - four hex digits, [3:0] is digit 0 (rightmost)
//                  dp_in      - decimal-point request per digit, active-high
//                  x          - nibble of the selected digit (to hex decoder)
//                  an         - digit anode enables, active-low
//                  dp         - decimal-point segment, active-low
//                  frame_tick - one-cycle pulse after each digit 3 -> 0 wrap
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  x;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    // Producer of display data / consumer of the scanned outputs.
    modport master (
        output load, value, dp_in,
        input  x, an, dp, frame_tick
    );

    // The scan driver itself.
    modport slave (
        input  load, value, dp_in,
        output x, an, dp, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed driver for a four-digit seven-segment
//                display. Each digit is shown for REFRESH_DIV clocks. New
//                data is captured into a pending register on load and only
//                transferred to the display register at the frame boundary
//                (digit 3 -> 0), so a frame never mixes two values. Optional
//                leading-zero suppression blanks the anode (and decimal
//                point) of upper digits whose nibbles and all higher nibbles
//                are zero.
//  Ports       : clk   - system clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - seg_scan_driver_if.slave (load/value/dp_in in;
//                        x/an/dp/frame_tick out, all outputs registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int REFRESH_DIV   = 50000,   // clocks per digit, 2..2^20
    parameter int LEADING_BLANK = 1        // 1 = suppress leading zeros
) (
    input  wire logic         clk,
    input  wire logic         reset,
    seg_scan_driver_if.slave  bus
);

    localparam int                C_PS_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [C_PS_W-1:0] C_TC   = C_PS_W'(REFRESH_DIV - 1);

    logic [C_PS_W-1:0] prescaler_q, prescaler_d;
    logic [1:0]        digit_q, digit_d;
    logic [15:0]       pend_val_q, pend_val_d;
    logic [3:0]        pend_dp_q, pend_dp_d;
    logic [15:0]       disp_val_q, disp_val_d;
    logic [3:0]        disp_dp_q, disp_dp_d;
    logic [3:0]        x_q, x_d;
    logic [3:0]        an_q, an_d;
    logic              dp_q, dp_d;
    logic              frame_tick_q, frame_tick_d;

    logic              tc;
    logic              boundary;
    logic [3:0]        nib_zero;
    logic [3:0]        blank;

    always_comb begin
        tc       = (prescaler_q == C_TC);
        // The terminal count that leaves digit 3 starts a new frame.
        boundary = tc && (digit_q == 2'd3);

        prescaler_d = tc ? '0 : prescaler_q + 1'b1;
        digit_d     = tc ? digit_q + 2'd1 : digit_q;

        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
        end

        // Display takes the pending value as it stood before this edge, so a
        // load landing on the boundary edge waits for the next frame.
        disp_val_d = boundary ? pend_val_q : disp_val_q;
        disp_dp_d  = boundary ? pend_dp_q  : disp_dp_q;

        for (int i = 0; i < 4; i++) begin
            nib_zero[i] = (disp_val_d[4*i +: 4] == 4'h0);
        end

        // Digit n is blank when nibbles n..3 are all zero; digit 0 never is.
        blank = (LEADING_BLANK != 0)
              ? {nib_zero[3], &nib_zero[3:2], &nib_zero[3:1], 1'b0}
              : 4'h0;

        x_d          = x_q;
        an_d         = an_q;
        dp_d         = dp_q;
        frame_tick_d = boundary;

        // Outputs follow the new digit index and the display register as
        // updated on this same edge.
        if (tc) begin
            x_d = disp_val_d[{digit_d, 2'b00} +: 4];
            if (blank[digit_d]) begin
                an_d = 4'hF;
                dp_d = 1'b1;
            end else begin
                an_d = ~(4'b0001 << digit_d);
                dp_d = ~disp_dp_d[digit_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q  <= '0;
            digit_q      <= 2'd3;   // first terminal count becomes a 3->0 wrap
            pend_val_q   <= 16'h0000;
            pend_dp_q    <= 4'h0;
            disp_val_q   <= 16'h0000;
            disp_dp_q    <= 4'h0;
            x_q          <= 4'h0;
            an_q         <= 4'hF;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            digit_q      <= digit_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            x_q          <= x_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver. Two instances with
//                REFRESH_DIV=4 (leading blank on / off) share all stimulus.
//                Expected outputs come from an edge-counting reference model:
//                edge e after reset shows digit (e/DIV-1) mod 4, frames start
//                at e mod 4*DIV == DIV, where the display takes the pending
//                value held before that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int DIV = 4;
    localparam logic [9:0] C_RST_OUT = {4'h0, 4'hF, 1'b1, 1'b0};

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;

    int total = 0;
    int bad   = 0;

    seg_scan_driver_if ia ();
    seg_scan_driver_if ib ();

    assign ia.load  = load;
    assign ia.value = value;
    assign ia.dp_in = dp_in;
    assign ib.load  = load;
    assign ib.value = value;
    assign ib.dp_in = dp_in;

    seg_scan_driver #(.REFRESH_DIV(DIV), .LEADING_BLANK(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    seg_scan_driver #(.REFRESH_DIV(DIV), .LEADING_BLANK(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    always #5 clk = ~clk;

    logic [9:0] oa, ob, ea, eb;
    assign oa = {ia.x, ia.an, ia.dp, ia.frame_tick};
    assign ob = {ib.x, ib.an, ib.dp, ib.frame_tick};

    // ---------------- reference model ----------------
    int unsigned m_e    = 0;        // rising edges since reset release
    logic [19:0] m_pend = 20'h0;    // {dp, value}
    logic [19:0] m_disp = 20'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_e    = 0;
            m_pend = 20'h0;
            m_disp = 20'h0;
        end else begin
            m_e = m_e + 1;
            if ((m_e % (4*DIV)) == DIV) m_disp = m_pend;
            if (load) m_pend = {dp_in, value};
        end
    end

    function automatic logic [9:0] exp_out(int unsigned e, logic [19:0] disp, bit lb);
        int       d;
        logic [3:0] x, an;
        logic     dpo, ft, blk;
        if (e < DIV) return C_RST_OUT;
        d   = int'(((e / DIV) - 1) % 4);
        x   = disp[4*d +: 4];
        blk = lb && (d >= 1) && ((disp[15:0] >> (4*d)) == 16'h0);
        an  = 4'hF;
        if (!blk) an[d] = 1'b0;
        dpo = blk ? 1'b1 : ~disp[16+d];
        ft  = ((e % (4*DIV)) == DIV);
        return {x, an, dpo, ft};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dp_in = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total += 2;
        if (oa !== C_RST_OUT) begin bad++; $display("FAIL reset_async_a got=%h exp=%h", oa, C_RST_OUT); end
        if (ob !== C_RST_OUT) begin bad++; $display("FAIL reset_async_b got=%h exp=%h", ob, C_RST_OUT); end
        load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        total += 2;
        if (oa !== C_RST_OUT) begin bad++; $display("FAIL reset_hold_a got=%h exp=%h", oa, C_RST_OUT); end
        if (ob !== C_RST_OUT) begin bad++; $display("FAIL reset_hold_b got=%h exp=%h", ob, C_RST_OUT); end
    endtask

    task automatic test_scan();
        do_reset();
        load = 1'b1; value = 16'h1234; dp_in = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            eb = exp_out(m_e, m_disp, 1'b0);
            total += 2;
            if (oa !== ea) begin bad++; $display("FAIL scan_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (ob !== eb) begin bad++; $display("FAIL scan_b e=%0d got=%h exp=%h", m_e, ob, eb); end
            if (m_e == 4) begin
                total++;
                if ({ia.an, ia.x, ia.frame_tick, ia.dp} !== {4'b1110, 4'h4, 1'b1, 1'b1}) begin
                    bad++; $display("FAIL scan_first_digit got=%b exp=%b", {ia.an, ia.x, ia.frame_tick, ia.dp}, {4'b1110, 4'h4, 1'b1, 1'b1});
                end
            end
            if (m_e == 8 || m_e == 12 || m_e == 16) begin
                total++;
                if ({ia.an, ia.x, ia.frame_tick, ia.dp} !== {~(4'b0001 << (m_e/4 - 1)), 4'(5 - m_e/4), 1'b0, 1'b1}) begin
                    bad++; $display("FAIL scan_digit e=%0d got=%b", m_e, {ia.an, ia.x, ia.frame_tick, ia.dp});
                end
            end
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    task automatic test_blank();
        do_reset();
        load = 1'b1; value = 16'h0005;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            eb = exp_out(m_e, m_disp, 1'b0);
            total += 2;
            if (oa !== ea) begin bad++; $display("FAIL blank_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (ob !== eb) begin bad++; $display("FAIL blank_b e=%0d got=%h exp=%h", m_e, ob, eb); end
            if (m_e == 8) begin
                total++;
                if ({ia.an, ib.an, ib.x} !== {4'b1111, 4'b1101, 4'h0}) begin
                    bad++; $display("FAIL blank_digit1 got=%b exp=%b", {ia.an, ib.an, ib.x}, {4'b1111, 4'b1101, 4'h0});
                end
            end
            if (m_e == 24) begin
                total++;
                if ({ia.an, ia.x} !== {4'b1111, 4'h0}) begin
                    bad++; $display("FAIL blank_zero_digit1 got=%b exp=%b", {ia.an, ia.x}, {4'b1111, 4'h0});
                end
            end
            @(negedge clk);
            load  = (m_e == 10);
            value = 16'h0000;
        end
    endtask

    task automatic test_mid_frame_load();
        do_reset();
        load = 1'b1; value = 16'h1234;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            eb = exp_out(m_e, m_disp, 1'b0);
            total += 2;
            if (oa !== ea) begin bad++; $display("FAIL midload_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (ob !== eb) begin bad++; $display("FAIL midload_b e=%0d got=%h exp=%h", m_e, ob, eb); end
            if (m_e == 12 || m_e == 16 || m_e == 20 || m_e == 32) begin
                total++;
                if (ia.x !== ((m_e == 12) ? 4'h2 : (m_e == 16) ? 4'h1 : (m_e == 20) ? 4'hD : 4'hA)) begin
                    bad++; $display("FAIL midload_x e=%0d got=%h", m_e, ia.x);
                end
            end
            @(negedge clk);
            load  = (m_e == 9);
            value = 16'hABCD;
        end
    endtask

    task automatic test_boundary_load();
        do_reset();
        load = 1'b1; value = 16'h1111;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            eb = exp_out(m_e, m_disp, 1'b0);
            total += 2;
            if (oa !== ea) begin bad++; $display("FAIL bndload_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (ob !== eb) begin bad++; $display("FAIL bndload_b e=%0d got=%h exp=%h", m_e, ob, eb); end
            if (m_e == 20 || m_e == 24 || m_e == 28 || m_e == 32 || m_e == 36) begin
                total++;
                if (ia.x !== ((m_e == 36) ? 4'h8 : 4'h1)) begin
                    bad++; $display("FAIL bndload_x e=%0d got=%h", m_e, ia.x);
                end
            end
            @(negedge clk);
            load  = (m_e == 19);
            value = 16'h5678;
        end
    endtask

    task automatic test_dp();
        do_reset();
        load = 1'b1; value = 16'h0012; dp_in = 4'b0100;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            eb = exp_out(m_e, m_disp, 1'b0);
            total += 2;
            if (oa !== ea) begin bad++; $display("FAIL dp_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (ob !== eb) begin bad++; $display("FAIL dp_b e=%0d got=%h exp=%h", m_e, ob, eb); end
            if (m_e == 12) begin
                total++;
                if ({ia.dp, ia.an, ib.dp, ib.an} !== {1'b1, 4'b1111, 1'b0, 4'b1011}) begin
                    bad++; $display("FAIL dp_blanked got=%b exp=%b", {ia.dp, ia.an, ib.dp, ib.an}, {1'b1, 4'b1111, 1'b0, 4'b1011});
                end
            end
            if (m_e == 28) begin
                total++;
                if ({ia.dp, ia.an} !== {1'b0, 4'b1011}) begin
                    bad++; $display("FAIL dp_lit got=%b exp=%b", {ia.dp, ia.an}, {1'b0, 4'b1011});
                end
            end
            @(negedge clk);
            load  = (m_e == 13);
            value = 16'h0312;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load = 1'b1; value = 16'h1234;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            total++;
            if (oa !== ea) begin bad++; $display("FAIL arst_pre_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (i < 11) begin
                @(negedge clk);
                load = 1'b0;
            end
        end
        // digit 2 is now selected; abort mid-cycle
        #2 reset = 1'b1;
        #1;
        total += 2;
        if (oa !== C_RST_OUT) begin bad++; $display("FAIL arst_mid_a got=%h exp=%h", oa, C_RST_OUT); end
        if (ob !== C_RST_OUT) begin bad++; $display("FAIL arst_mid_b got=%h exp=%h", ob, C_RST_OUT); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            eb = exp_out(m_e, m_disp, 1'b0);
            total += 2;
            if (oa !== ea) begin bad++; $display("FAIL arst_post_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (ob !== eb) begin bad++; $display("FAIL arst_post_b e=%0d got=%h exp=%h", m_e, ob, eb); end
            if (m_e == 4) begin
                total++;
                if ({ia.an, ia.x, ia.frame_tick} !== {4'b1110, 4'h0, 1'b1}) begin
                    bad++; $display("FAIL arst_restart got=%b exp=%b", {ia.an, ia.x, ia.frame_tick}, {4'b1110, 4'h0, 1'b1});
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load  = ($urandom_range(0, 2) == 0);
            value = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            dp_in = 4'($urandom);
            @(posedge clk); #1;
            ea = exp_out(m_e, m_disp, 1'b1);
            eb = exp_out(m_e, m_disp, 1'b0);
            total += 2;
            if (oa !== ea) begin bad++; $display("FAIL rand_a e=%0d got=%h exp=%h", m_e, oa, ea); end
            if (ob !== eb) begin bad++; $display("FAIL rand_b e=%0d got=%h exp=%h", m_e, ob, eb); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_mid_frame_load();
        test_boundary_load();
        test_dp();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is displayed (legal range 2..2^20).
REQ-002 SHALL have parameter LEADING_BLANK, default 1, where 1 enables leading-zero suppression.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  when high at a clk edge, value and dp_in are captured.
REQ-006 SHALL have port value  input  16  four hex digits; [3:0] is digit 0 (rightmost).
REQ-007 SHALL have port dp_in  input  4  decimal-point request per digit, active-high; bit n belongs to digit n.
REQ-008 SHALL have port x  output  4  nibble of the currently selected digit, feeding the hex-to-7-segment decoder.
REQ-009 SHALL have port an  output  4  digit anode enables, active-low, one-hot-low or all-high.
REQ-010 SHALL have port dp  output  1  decimal-point segment, active-low.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse on each wrap from digit 3 to digit 0.

Function
REQ-012 SHALL hold a pending register (16+4 bits) that loads value/dp_in on every edge where load=1; the last load before a frame boundary wins.
REQ-013 SHALL hold a display register that is loaded from pending only on the frame-boundary edge (digit index 3->0), so that no frame mixes two values.
REQ-014 SHALL hold a prescaler that counts 0..REFRESH_DIV-1 and wraps to 0; the terminal count is prescaler==REFRESH_DIV-1.
REQ-015 SHALL hold a 2-bit digit index that increments modulo 4 on each terminal count and is otherwise held.
REQ-016 SHALL register x, an, dp and frame_tick; on the terminal-count edge they SHALL take the values of the new digit index, using the display register as updated on that same edge.
REQ-017 SHALL drive, for selected digit n: x=display[4n+3:4n]; an=all ones except bit n=0; dp=~display_dp[n].
REQ-018 SHALL, when LEADING_BLANK=1, blank digit n (n>=1) when display nibbles n..3 are all zero; a blanked digit SHALL drive an=4'b1111 and dp=1 while still driving x with its nibble; digit 0 SHALL never be blanked.
REQ-019 SHALL suppress the decimal point of a blanked digit, even when dp_in requested it.
REQ-020 SHALL assert frame_tick for exactly the one cycle following the 3->0 edge; it SHALL be 0 at all other times.
REQ-021 SHALL not capture a load that coincides with the frame-boundary edge into the frame starting at that edge (the display takes the old pending value); that load SHALL appear at the next boundary.
REQ-022 SHALL continue the prescaler and scan unaffected by load.

Reset
REQ-023 SHALL, while reset=1, force immediately (asynchronously): prescaler=0, digit index=3, pending=0, display=0, x=4'h0, an=4'b1111, dp=1, frame_tick=0.
REQ-024 SHALL, after reset deasserts, make the first terminal count a frame boundary (3->0), so digit 0 is first shown REFRESH_DIV edges after release.
REQ-025 SHALL allow reset asserted mid-frame to abort the frame, and SHALL discard pending loads.

Verification (REFRESH_DIV=4)
REQ-026 SHALL be tested as: reset release, load 16'h1234 dp_in=0 on edge 1 -> edge 4: an=1110 x=4 frame_tick=1 next cycle; edges 8/12/16: (1101,3),(1011,2),(0111,1); dp=1 throughout.
REQ-027 SHALL be tested as: load 16'h0005, LEADING_BLANK=1 -> digit0 an=1110 x=5; digits 1-3 an=1111; with LEADING_BLANK=0 -> all four anodes scan, x=0 on digits 1-3; load 16'h0000 -> only digit 0 lit, x=0.
REQ-028 SHALL be tested as: display 16'h1234 with load 16'hABCD during digit 1 -> digits 2,3 still show 2,1; next frame shows D,C,B,A.
REQ-029 SHALL be tested as: load 16'h5678 on the exact 3->0 edge while pending=16'h1111 -> that frame shows 1,1,1,1; following frame shows 8,7,6,5.
REQ-030 SHALL be tested as: dp_in=4'b0100 with value 16'h0012 and LEADING_BLANK=1 -> dp=0 only while digit 2 selected; since digit 2 is blanked, dp stays 1 there; with value 16'h0312, dp=0 and an=1011 for digit 2.
REQ-031 SHALL be tested as: reset asserted mid-cycle during digit 2 -> an=1111, x=0, dp=1, frame_tick=0 before the next clk edge; after release, the restart timing matches REQ-026.
